// File: rtl/vscale_imem_loader.sv
// Boot loader for vscale: unpacks a framed byte stream (length, little-endian words,
// XOR checksum) into imem and holds the core in reset until the image verifies.
module vscale_imem_loader #(
  parameter int ADDR_WIDTH  = 10,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic                  core_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  // Handshake: a byte transfers on a rising edge where in_valid and in_ready are both 1;
  // in_ready is registered, depends only on the loader state and never on in_valid.

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_CSUM, S_HOLD, S_RUN, S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          len_lo_q;
  logic [15:0]         len_q;
  logic [ADDR_WIDTH:0] words_rx_q;
  logic [1:0]          lane_q;
  logic [23:0]         word_q;
  logic [7:0]          csum_q;
  logic [HOLD_W-1:0]   hold_q;

  logic        accept;
  logic [15:0] len_full;
  logic        last_word;

  assign accept    = in_valid & in_ready;
  assign len_full  = {in_data, len_lo_q};
  assign last_word = (32'(words_rx_q) + 32'd1) == 32'(len_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN0: if (accept) state_d = S_LEN1;
      S_LEN1: if (accept) begin
        if (len_full == 16'd0)                              state_d = S_CSUM;
        else if (32'(len_full) > (32'd1 << ADDR_WIDTH))     state_d = S_ERROR;
        else                                                state_d = S_DATA;
      end
      S_DATA: if (accept && lane_q == 2'd3 && last_word) state_d = S_CSUM;
      S_CSUM: if (accept) state_d = (in_data == csum_q) ? S_HOLD : S_ERROR;
      S_HOLD: if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) state_d = S_RUN;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_LEN0;
      in_ready     <= 1'b0;
      mem_wen      <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      core_reset   <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      len_lo_q     <= '0;
      len_q        <= '0;
      words_rx_q   <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      hold_q       <= '0;
    end else begin
      state_q    <= state_d;
      in_ready   <= (state_d == S_LEN0) || (state_d == S_LEN1) ||
                    (state_d == S_DATA) || (state_d == S_CSUM);
      core_reset <= (state_d != S_RUN);
      load_done  <= (state_d == S_RUN);
      load_error <= (state_d == S_ERROR);
      mem_wen    <= 1'b0;
      // words_loaded counts write pulses already presented to imem
      if (mem_wen) words_loaded <= words_loaded + (ADDR_WIDTH + 1)'(1);
      if (state_q == S_HOLD) hold_q <= hold_q + HOLD_W'(1);
      if (accept) begin
        case (state_q)
          S_LEN0: len_lo_q <= in_data;
          S_LEN1: len_q    <= len_full;
          S_DATA: begin
            csum_q <= csum_q ^ in_data;
            lane_q <= lane_q + 2'd1;
            case (lane_q)
              2'd0: word_q[7:0]   <= in_data;
              2'd1: word_q[15:8]  <= in_data;
              2'd2: word_q[23:16] <= in_data;
              default: begin
                mem_wen    <= 1'b1;
                mem_wdata  <= {in_data, word_q};
                mem_waddr  <= words_rx_q[ADDR_WIDTH-1:0];
                words_rx_q <= words_rx_q + (ADDR_WIDTH + 1)'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end
endmodule
